prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 194 +++++++++++++++++++
 tb/tb_prbs_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS checker: locks onto an LFSR sequence, then flags and counts bit errors.
// Latency: locked changes on the edge of the deciding beat; err pulses 1 cycle after a bad beat.
// Backpressure: none. A beat is consumed on every cycle with in_valid=1. Idle cycles freeze all state.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   in_valid  in   1      in_bit holds a PRBS bit this cycle (one beat)
//   in_bit    in   1      received PRBS bit, oldest first
//   clear     in   1      synchronous clear of err_cnt (wins over a same-cycle increment)
//   locked    out  1      high while in the LOCKED state
//   err       out  1      one-cycle pulse per mismatching beat while LOCKED
//   err_cnt   out  CNT_W  saturating mismatch count
//
// Optional feature: define PRBS_CHECKER_ERRCNT_EN to build the error counter.
// Without it err_cnt is tied to zero and clear is ignored.

module prbs_checker #(
    parameter int              N          = 7,
    parameter logic [N-1:0]    TAPS       = 7'b110_0000,
    parameter int              LOCK_CNT   = 16,
    parameter int              WINDOW     = 128,
    parameter int              ERR_THRESH = 8,
    parameter int              CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    // Terminal values are compared against the pre-increment count, so the
    // beat that would bring a counter to its limit is detected one step early.
    localparam logic [7:0]  LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [15:0] WINDOW_LAST = 16'(WINDOW - 1);
    localparam logic [15:0] THRESH_LAST = 16'(ERR_THRESH - 1);

    typedef enum logic {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t       r_state;
    logic [N-1:0] r_hist;        // bit 0 is the newest bit
    logic [7:0]   r_match_cnt;
    logic [15:0]  r_win_bits;
    logic [15:0]  r_win_err;
    logic         r_err;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t       w_state_nxt;
    logic [N-1:0] w_hist_nxt;
    logic [7:0]   w_match_nxt;
    logic [15:0]  w_win_bits_nxt;
    logic [15:0]  w_win_err_nxt;
    logic         w_err_nxt;

    logic         w_pred;
    logic         w_hist_zero;
    logic         w_hunt_match;
    logic         w_lock_mismatch;

    // Predicted next bit from the local copy of the generator state.
    assign w_pred      = ^(r_hist & TAPS);
    assign w_hist_zero = (r_hist == '0);

    // An empty history would predict 0 forever and lock onto a dead line,
    // so matches only count once at least one 1 has been seen.
    assign w_hunt_match    = !w_hist_zero && (in_bit == w_pred);
    assign w_lock_mismatch = (in_bit != w_pred);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_hist_nxt     = r_hist;
        w_match_nxt    = r_match_cnt;
        w_win_bits_nxt = r_win_bits;
        w_win_err_nxt  = r_win_err;
        w_err_nxt      = 1'b0;

        if (in_valid) begin
            case (r_state)
                S_HUNT: begin
                    // While hunting, the history is loaded straight from the
                    // line so it converges to the sender's state.
                    w_hist_nxt = {r_hist[N-2:0], in_bit};
                    if (w_hunt_match) begin
                        if (r_match_cnt == LOCK_LAST) begin
                            w_state_nxt    = S_LOCKED;
                            w_match_nxt    = '0;
                            w_win_bits_nxt = '0;
                            w_win_err_nxt  = '0;
                        end else begin
                            w_match_nxt = r_match_cnt + 8'd1;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end

                S_LOCKED: begin
                    // Once locked, the history free-runs on its own prediction
                    // so line errors cannot corrupt the reference.
                    w_hist_nxt     = {r_hist[N-2:0], w_pred};
                    w_win_bits_nxt = r_win_bits + 16'd1;
                    if (w_lock_mismatch) begin
                        w_err_nxt     = 1'b1;
                        w_win_err_nxt = r_win_err + 16'd1;
                    end

                    // Threshold check is evaluated before the window roll-over
                    // so a threshold hit on the last window beat still drops lock.
                    if (w_lock_mismatch && (r_win_err == THRESH_LAST)) begin
                        w_state_nxt    = S_HUNT;
                        w_match_nxt    = '0;
                        w_win_bits_nxt = '0;
                        w_win_err_nxt  = '0;
                    end else if (r_win_bits == WINDOW_LAST) begin
                        // A new window starts clean; an error on this beat is dropped.
                        w_win_bits_nxt = '0;
                        w_win_err_nxt  = '0;
                    end
                end

                default: begin
                    w_state_nxt = S_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_HUNT;
            r_hist      <= '0;
            r_match_cnt <= '0;
            r_win_bits  <= '0;
            r_win_err   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hist      <= w_hist_nxt;
            r_match_cnt <= w_match_nxt;
            r_win_bits  <= w_win_bits_nxt;
            r_win_err   <= w_win_err_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign locked = (r_state == S_LOCKED);
    assign err    = r_err;

    // ------------------------------------------------------------------
    // Optional saturating error counter
    // ------------------------------------------------------------------
`ifdef PRBS_CHECKER_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_cnt_full;

    assign w_cnt_full = (r_err_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clear) begin
            r_err_cnt <= '0;
        end else if (w_err_nxt && !w_cnt_full) begin
            r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_clear;

    assign w_unused_clear = clear;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

    localparam int           N          = 7;
    localparam logic [N-1:0] TAPS       = 7'b110_0000;
    localparam int           LOCK_CNT   = 16;
    localparam int           WINDOW     = 128;
    localparam int           ERR_THRESH = 8;

`ifdef PRBS_CHECKER_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_bit   = 1'b0;
    logic        clear    = 1'b0;

    logic        locked_a, err_a;
    logic [15:0] cnt_a;
    logic        locked_b, err_b;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    prbs_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW),
                   .ERR_THRESH(ERR_THRESH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
        .locked(locked_a), .err(err_a), .err_cnt(cnt_a));

    prbs_checker #(.N(N), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW),
                   .ERR_THRESH(ERR_THRESH), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
        .locked(locked_b), .err(err_b), .err_cnt(cnt_b));

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   beat_no = 0;

    // Reference checker state
    bit         m_locked;
    logic [6:0] m_h;
    int         m_match, m_wb, m_we, m_c16, m_c4;
    bit         m_err;
    // Upstream PRBS7 (x^7 + x^6 + 1) generator
    logic [6:0] g_st;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic gen_next();
        logic b;
        b    = g_st[6] ^ g_st[5];
        g_st = {g_st[5:0], b};
        return b;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_h = '0; m_match = 0; m_wb = 0; m_we = 0;
        m_c16 = 0; m_c4 = 0; m_err = 0;
        g_st = 7'h7F;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        bit p;
        m_err = 0;
        if (v) begin
            p = m_h[6] ^ m_h[5];
            if (!m_locked) begin
                if (m_h != 0 && b == p) m_match++; else m_match = 0;
                m_h = {m_h[5:0], b};
                if (m_match == LOCK_CNT) begin
                    m_locked = 1; m_match = 0; m_wb = 0; m_we = 0;
                end
            end else begin
                m_h = {m_h[5:0], p};
                m_wb++;
                if (b != p) begin
                    m_err = 1;
                    m_we++;
                    if (m_c16 < 65535) m_c16++;
                    if (m_c4 < 15) m_c4++;
                end
                if (b != p && m_we == ERR_THRESH) begin
                    m_locked = 0; m_match = 0; m_wb = 0; m_we = 0;
                end else if (m_wb == WINDOW) begin
                    m_wb = 0; m_we = 0;
                end
            end
        end
        if (c) begin m_c16 = 0; m_c4 = 0; end
    endtask

    // One clock: drive at the falling edge, push the expectation, compare after the rising edge.
    task automatic beat_raw(input bit v, input bit b, input bit c);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_bit = b; clear = c;
        model_step(v, b, c);
        e.locked = m_locked;
        e.err    = m_err;
        e.cnt16  = ERRCNT_EN ? 16'(m_c16) : 16'd0;
        e.cnt4   = ERRCNT_EN ? 4'(m_c4)   : 4'd0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        beat_no++;
        e = sb_q.pop_front();
        check($sformatf("locked16@%0d", beat_no), {15'd0, locked_a}, {15'd0, e.locked});
        check($sformatf("err16@%0d", beat_no),    {15'd0, err_a},    {15'd0, e.err});
        check($sformatf("cnt16@%0d", beat_no),    cnt_a,             e.cnt16);
        check($sformatf("locked4@%0d", beat_no),  {15'd0, locked_b}, {15'd0, e.locked});
        check($sformatf("err4@%0d", beat_no),     {15'd0, err_b},    {15'd0, e.err});
        check($sformatf("cnt4@%0d", beat_no),     {12'd0, cnt_b},    {12'd0, e.cnt4});
    endtask

    task automatic prbs_beat(input bit v, input bit inv, input bit c);
        logic b;
        if (v) b = gen_next() ^ inv;
        else   b = 1'($urandom_range(0, 1));
        beat_raw(v, b, c);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_locked16"}, {15'd0, locked_a}, 16'd0);
        check({tag, "_err16"},    {15'd0, err_a},    16'd0);
        check({tag, "_cnt16"},    cnt_a,             16'd0);
        check({tag, "_locked4"},  {15'd0, locked_b}, 16'd0);
        check({tag, "_err4"},     {15'd0, err_b},    16'd0);
        check({tag, "_cnt4"},     {12'd0, cnt_b},    16'd0);
    endtask

    // Asynchronous reset: outputs are checked 1 time unit after rst rises, before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
        #1;
        check_idle_outputs(tag);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts valid beats until the DUT reports lock, bounded.
    task automatic run_until_lock(input bit toggle, output int beats);
        int  guard;
        bit  v;
        beats = 0;
        guard = 0;
        while (!locked_a && guard < 400) begin
            v = toggle ? (guard % 2 == 1) : 1'b1;
            prbs_beat(v, 1'b0, 1'b0);
            if (v) beats++;
            guard++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;

        // Reset state
        do_reset("reset");

        // Clean PRBS7 from seed 7F: lock on beat 23
        run_until_lock(1'b0, n);
        check("lock_beat", 16'(n), 16'd23);
        for (int i = 0; i < 20; i++) prbs_beat(1'b1, 1'b0, 1'b0);

        // Single inverted beat
        prbs_beat(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) prbs_beat(1'b1, 1'b0, 1'b0);
        check("single_err_locked", {15'd0, locked_a}, 16'd1);
        check("single_err_cnt", cnt_a, ERRCNT_EN ? 16'd1 : 16'd0);

        // Move to a fresh window, then 8 errors inside it
        guard = 0;
        while (m_wb != 0 && guard < 200) begin
            prbs_beat(1'b1, 1'b0, 1'b0);
            guard++;
        end
        for (int i = 0; i < 8; i++) begin
            prbs_beat(1'b1, 1'b1, 1'b0);
            if (i == 6) check("pre_thresh_locked", {15'd0, locked_a}, 16'd1);
            if (i < 7) prbs_beat(1'b1, 1'b0, 1'b0);
        end
        check("thresh_unlock", {15'd0, locked_a}, 16'd0);
        run_until_lock(1'b0, n);
        check("relock_beats", 16'(n), 16'd16);

        // Clear on an idle cycle, then 7 errors per window for 4 windows
        beat_raw(1'b0, 1'b0, 1'b1);
        for (int w = 0; w < 4; w++) begin
            for (int p = 0; p < WINDOW; p++) begin
                prbs_beat(1'b1, (p % 10 == 0) && (p >= 10) && (p <= 70), 1'b0);
            end
        end
        check("win7_locked", {15'd0, locked_a}, 16'd1);
        check("win7_cnt16", cnt_a, ERRCNT_EN ? 16'd28 : 16'd0);
        check("win7_cnt4_sat", {12'd0, cnt_b}, ERRCNT_EN ? 16'd15 : 16'd0);

        // Clear coincident with an error beat: count zero, err still pulses
        prbs_beat(1'b1, 1'b1, 1'b1);
        check("clr_err_pulse", {15'd0, err_a}, 16'd1);
        check("clr_err_cnt16", cnt_a, 16'd0);
        check("clr_err_cnt4", {12'd0, cnt_b}, 16'd0);
        for (int i = 0; i < 5; i++) prbs_beat(1'b1, (i == 2), 1'b0);

        // Reset mid-lock
        do_reset("midlock_rst");

        // Constant zero never locks
        for (int i = 0; i < 1000; i++) beat_raw(1'b1, 1'b0, 1'b0);
        check("zeros_unlocked", {15'd0, locked_a}, 16'd0);

        // 50% valid duty: same lock beat count
        do_reset("reset2");
        run_until_lock(1'b1, n);
        check("toggle_lock_beat", 16'(n), 16'd23);
        for (int i = 0; i < 10; i++) prbs_beat(1'(i % 2), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
